// File: rtl/mem_wait_responder.sv
// Memory-side responder for a multi-cycle CPU's shared instruction/data port.
// Serves one access at a time after WAIT_CYCLES wait states and flags illegal accesses.
module mem_wait_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Mem_data,
  output logic        Mem_ready,
  output logic        Mem_error,
  output logic        Busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [31:0]           wdata_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  err_q;
  logic [31:0]           rd_data_q;
  logic [31:0]           mem [DEPTH];

  logic        req;
  logic        misaligned;
  logic        out_of_range;
  logic        conflict;
  logic        capture_err;
  logic        resp;
  logic        op_read;
  logic [31:0] resp_data;

  // Error class is decided from the raw inputs at the capture edge only.
  assign req          = MemRead | MemWrite;
  assign misaligned   = |Address[1:0];
  assign out_of_range = |Address[31:ADDR_WIDTH+2];
  assign conflict     = MemRead & MemWrite;
  assign capture_err  = misaligned | out_of_range | conflict;

  assign resp    = (state == S_RESP);
  assign op_read = rd_q & ~wr_q;

  // NOTE: plain continuous assignments here; no storage is implied, so no latch can form.
  assign resp_data = err_q ? 32'd0 : mem[word_q];

  // Read data appears combinationally in RESP and is held by rd_data_q afterwards.
  assign Mem_data  = (resp && op_read) ? resp_data : rd_data_q;
  assign Mem_ready = resp;
  assign Mem_error = resp & err_q;
  assign Busy      = (state != S_IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      word_q    <= '0;
      wdata_q   <= 32'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            word_q  <= Address[ADDR_WIDTH+1:2];
            wdata_q <= Write_data;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            err_q   <= capture_err;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          if (op_read) begin
            rd_data_q <= resp_data;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the array is cleared by reset because software expects zeroed memory
  // after reset; this costs a reset net on every word, which is accepted here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (resp && wr_q && !err_q) begin
      mem[word_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Self-checking bench: three responders (2, 0 and 3 wait states) on shared stimulus,
// checked one at a time against a word-array reference model.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;

  logic [31:0] md0, md1, md2;
  logic        rdy0, rdy1, rdy2;
  logic        err0, err1, err2;
  logic        bsy0, bsy1, bsy2;

  always #5 clk = ~clk;

  mem_wait_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_data(md0), .Mem_ready(rdy0), .Mem_error(err0), .Busy(bsy0)
  );

  mem_wait_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_data(md1), .Mem_ready(rdy1), .Mem_error(err1), .Busy(bsy1)
  );

  mem_wait_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem_data(md2), .Mem_ready(rdy2), .Mem_error(err2), .Busy(bsy2)
  );

  int          sel;
  int          wait_of [3] = '{2, 0, 3};
  logic [31:0] cur_data;
  logic        cur_ready, cur_error, cur_busy;

  always_comb begin
    cur_data  = md0;
    cur_ready = rdy0;
    cur_error = err0;
    cur_busy  = bsy0;
    case (sel)
      1: begin cur_data = md1; cur_ready = rdy1; cur_error = err1; cur_busy = bsy1; end
      2: begin cur_data = md2; cur_ready = rdy2; cur_error = err2; cur_busy = bsy2; end
      default: ;
    endcase
  end

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_data;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    model_data = 32'd0;
  endtask

  task automatic do_reset();
    MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; Write_data = 32'd0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // One transaction. b2b: previous call held its request, so one idle cycle precedes capture.
  // hold: leave the request asserted for a following b2b call.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold, input bit b2b,
                        input bit scramble, input string name);
    int          lat;
    int          k;
    bit          e;
    logic [31:0] exp_data;
    e = (addr[1:0] != 2'd0) || (addr[31:10] != 22'd0) || (rd && wr);
    exp_data = model_data;
    if (rd && !wr) exp_data = e ? 32'd0 : model_mem[addr[9:2]];
    lat = wait_of[sel] + 1 + (b2b ? 1 : 0);
    Address = addr; Write_data = data; MemRead = rd; MemWrite = wr;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (b2b && k == 1) begin
        tests++;
        if (cur_busy !== 1'b0 || cur_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s idle_gap: busy=%b ready=%b expected 0 0", name, cur_busy, cur_ready);
        end
      end else if (!cur_ready) begin
        tests++;
        if (cur_busy !== 1'b1) begin
          fails++;
          $display("FAIL %s busy_wait cycle %0d: busy=%b expected 1", name, k, cur_busy);
        end
      end
      if (scramble && k == 1) begin
        Address = $urandom; Write_data = $urandom; MemWrite = ~wr;
      end
    end while (!cur_ready && k < 20);
    tests++;
    if (k !== lat) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, k, lat);
    end
    tests++;
    if (cur_busy !== 1'b1 || cur_error !== e) begin
      fails++;
      $display("FAIL %s resp_flags: busy=%b error=%b expected 1 %b", name, cur_busy, cur_error, e);
    end
    tests++;
    if (cur_data !== exp_data) begin
      fails++;
      $display("FAIL %s resp_data: got %h expected %h", name, cur_data, exp_data);
    end
    if (!e && wr) model_mem[addr[9:2]] = data;
    model_data = exp_data;
    if (scramble) begin
      Address = addr; Write_data = data; MemWrite = wr;
    end
    if (!hold) begin
      MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (cur_ready !== 1'b0 || cur_busy !== 1'b0 || cur_error !== 1'b0 || cur_data !== model_data) begin
        fails++;
        $display("FAIL %s after_resp: ready=%b busy=%b error=%b data=%h expected 0 0 0 %h",
                 name, cur_ready, cur_busy, cur_error, cur_data, model_data);
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    tests++;
    if (cur_data !== 32'd0 || cur_ready !== 1'b0 || cur_error !== 1'b0 || cur_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: data=%h ready=%b error=%b busy=%b expected all 0",
               cur_data, cur_ready, cur_error, cur_busy);
    end
  endtask

  task automatic test_basic_read();
    access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, "read_0x10");
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, "b2b_write_0x40");
    access(1'b1, 1'b0, 32'h40, 32'd0,        1'b0, 1'b1, 1'b0, "b2b_read_0x40");
  endtask

  task automatic test_errors();
    access(1'b1, 1'b0, 32'h42,  32'd0,        1'b0, 1'b0, 1'b0, "read_misaligned");
    access(1'b1, 1'b0, 32'h40,  32'd0,        1'b0, 1'b0, 1'b0, "reload_0x40");
    access(1'b1, 1'b0, 32'h400, 32'd0,        1'b0, 1'b0, 1'b0, "read_out_of_range");
    access(1'b0, 1'b1, 32'h400, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, "write_out_of_range");
    access(1'b1, 1'b0, 32'h0,   32'd0,        1'b0, 1'b0, 1'b0, "read_word0");
  endtask

  task automatic test_conflict();
    access(1'b0, 1'b1, 32'h8,  32'h12345678, 1'b0, 1'b0, 1'b0, "write_0x8");
    access(1'b1, 1'b0, 32'h40, 32'd0,        1'b0, 1'b0, 1'b0, "prime_data");
    access(1'b1, 1'b1, 32'h8,  32'hFFFF0000, 1'b0, 1'b0, 1'b0, "conflict_0x8");
    access(1'b1, 1'b0, 32'h8,  32'd0,        1'b0, 1'b0, 1'b0, "read_0x8");
  endtask

  task automatic test_reset_mid();
    Address = 32'hC; Write_data = 32'hCAFEF00D; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (cur_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_capture: busy=%b expected 1", cur_busy);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (cur_data !== 32'd0 || cur_ready !== 1'b0 || cur_error !== 1'b0 || cur_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: data=%h ready=%b error=%b busy=%b expected all 0",
               cur_data, cur_ready, cur_error, cur_busy);
    end
    do_reset();
    access(1'b1, 1'b0, 32'hC, 32'd0, 1'b0, 1'b0, 1'b0, "read_after_abort");
  endtask

  task automatic test_zero_wait();
    sel = 1;
    do_reset();
    access(1'b0, 1'b1, 32'h4, 32'h1, 1'b0, 1'b0, 1'b0, "w0_write_0x4");
    access(1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 1'b0, "w0_read_0x4");
  endtask

  task automatic test_input_change();
    sel = 2;
    do_reset();
    access(1'b0, 1'b1, 32'h20, $urandom, 1'b0, 1'b0, 1'b1, "w3_write_scrambled");
    access(1'b1, 1'b0, 32'h20, 32'd0,    1'b0, 1'b0, 1'b1, "w3_read_scrambled");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic        rd, wr;
    bit          hold, prev_hold;
    int          op, kind;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      prev_hold = 1'b0;
      for (int i = 0; i < 40; i++) begin
        op = $urandom_range(0, 9);
        rd = (op <= 4) || (op == 9);
        wr = (op >= 5);
        kind = $urandom_range(0, 9);
        if (kind <= 7)      addr = 32'($urandom_range(0, 15)) << 2;
        else if (kind == 8) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        else                addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
        hold = (i < 39) && ($urandom_range(0, 1) == 1);
        access(rd, wr, addr, $urandom, hold, prev_hold,
               !prev_hold && ($urandom_range(0, 3) == 0), $sformatf("rand_d%0d_%0d", s, i));
        prev_hold = hold;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    sel = 0;
    MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; Write_data = 32'd0;
    model_reset();
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_errors();
    test_conflict();
    test_reset_mid();
    test_zero_wait();
    test_input_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
